rggen_bus_initiator: RTL and testbench

Bus initiator that drives `rggen_bus_if` as master, issuing one register access at a time. It converts a valid/ready command stream, from a CPU bridge, test sequencer or DMA-style config loader, into protocol-compliant bus requests. It returns a valid/ready response stream carrying status, read data and a timeout flag. It sits on the opposite end of `rggen_bus_if` from the register-block adapters.

---
 rtl/rggen_rtl_pkg.sv | 21 ++
 rtl/rggen_bus_if.sv | 26 ++
 rtl/rggen_bus_initiator.sv | 98 +++++++++
 tb/tb_rggen_bus_initiator.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared bus access/status encodings and the initiator FSM state
package rggen_rtl_pkg;
    typedef enum logic [1:0] {
        RGGEN_READ         = 2'b00,
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } rggen_bus_initiator_state;
endpackage

// File: rtl/rggen_bus_if.sv
// rggen_bus_if: single-outstanding register bus between an initiator and register-block adapters
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_bus_initiator.sv
// rggen_bus_initiator: turns a valid/ready command stream into one-at-a-time rggen bus accesses
module rggen_bus_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int TIMEOUT       = 0
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  rggen_access              i_cmd_access,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output rggen_status              o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic                     o_rsp_timeout,
    rggen_bus_if.master              bus_if
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    rggen_bus_initiator_state state_q;
    rggen_access              access_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [BUS_WIDTH-1:0]     write_data_q;
    logic [BUS_WIDTH/8-1:0]   strobe_q;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    rggen_status              status_q;
    logic [BUS_WIDTH-1:0]     read_data_q;
    logic                     timeout_q;
    logic                     timeout_d;
    logic                     accept;

    assign o_cmd_ready       = (state_q == IDLE) || ((state_q == RESP) && i_rsp_ready);
    assign accept            = i_cmd_valid && o_cmd_ready;
    assign bus_if.valid      = state_q == BUS;
    assign bus_if.access     = access_q;
    assign bus_if.address    = address_q;
    assign bus_if.write_data = write_data_q;
    assign bus_if.strobe     = strobe_q;
    assign o_rsp_valid       = state_q == RESP;
    assign o_rsp_status      = status_q;
    assign o_rsp_read_data   = read_data_q;
    assign o_rsp_timeout     = timeout_q;

    // saturating wait count; completing on the cycle it would hit the limit also flags timeout
    always_comb begin
        cnt_d     = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
        timeout_d = (TIMEOUT != 0) && ((cnt_q == LIMIT) || (cnt_d == LIMIT));
    end

    // command/bus/response sequencing with the request and response held in registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            access_q     <= RGGEN_READ;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            cnt_q        <= '0;
            status_q     <= RGGEN_OKAY;
            read_data_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                BUS: begin
                    if (bus_if.ready) begin
                        state_q     <= RESP;
                        status_q    <= bus_if.status;
                        read_data_q <= bus_if.read_data;
                        timeout_q   <= timeout_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                IDLE, RESP: begin
                    if (accept) begin
                        state_q      <= BUS;
                        access_q     <= i_cmd_access;
                        address_q    <= i_cmd_address;
                        write_data_q <= i_cmd_write_data;
                        strobe_q     <= i_cmd_strobe;
                        cnt_q        <= '0;
                    end else if ((state_q == RESP) && i_rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_bus_initiator.sv
// tb_rggen_bus_initiator: directed and random transactions against a transaction-level model
module tb_rggen_bus_initiator;
    import rggen_rtl_pkg::*;

    localparam int AW = 8;
    localparam int BW = 32;
    localparam int TO = 4;

    typedef struct {
        rggen_access    acc;
        logic [AW-1:0]  addr;
        logic [BW-1:0]  wd;
        logic [BW/8-1:0] strb;
        int             w;
        rggen_status    st;
        logic [BW-1:0]  rd;
        int             acc_c;
        bit             lat;
    } txn_t;

    typedef struct {
        rggen_access    acc;
        logic [AW-1:0]  addr;
        logic [BW-1:0]  wd;
        logic [BW/8-1:0] strb;
        int             vcyc;
        bit             stable;
    } req_t;

    typedef struct {
        rggen_status   st;
        logic [BW-1:0] rd;
        logic          to;
        int            c;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid;
    logic            cmd_ready;
    rggen_access     cmd_access;
    logic [AW-1:0]   cmd_address;
    logic [BW-1:0]   cmd_wdata;
    logic [BW/8-1:0] cmd_strobe;
    logic            rsp_valid;
    logic            rsp_ready;
    rggen_status     rsp_status;
    logic [BW-1:0]   rsp_rdata;
    logic            rsp_timeout;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    txn_t cfg_q[$];
    txn_t exp_q[$];
    req_t req_log[$];
    rsp_t rsp_log[$];

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_if ();

    rggen_bus_initiator #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT(TO)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_access     (cmd_access),
        .i_cmd_address    (cmd_address),
        .i_cmd_write_data (cmd_wdata),
        .i_cmd_strobe     (cmd_strobe),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_status     (rsp_status),
        .o_rsp_read_data  (rsp_rdata),
        .o_rsp_timeout    (rsp_timeout),
        .bus_if           (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // slave model: answers each request after its configured number of wait cycles
    initial begin : slave
        int   n;
        txn_t cur;
        n = 0;
        cur.w = 0;
        cur.st = RGGEN_OKAY;
        cur.rd = '0;
        bus_if.ready = 1'b0;
        bus_if.status = RGGEN_OKAY;
        bus_if.read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.valid) begin
                if (n == 0 && cfg_q.size() > 0) cur = cfg_q.pop_front();
                bus_if.ready = (n == cur.w);
                bus_if.status = cur.st;
                bus_if.read_data = cur.rd;
                n++;
            end else begin
                bus_if.ready = 1'b0;
                n = 0;
            end
        end
    end

    // monitor: logs completed bus requests (with stability) and response handshakes
    initial begin : monitor
        req_t r;
        int   vn;
        vn = 0;
        forever begin
            @(negedge clk);
            if (bus_if.valid) begin
                if (vn == 0) begin
                    r.acc = bus_if.access;
                    r.addr = bus_if.address;
                    r.wd = bus_if.write_data;
                    r.strb = bus_if.strobe;
                    r.stable = 1'b1;
                end else if (r.acc !== bus_if.access || r.addr !== bus_if.address ||
                             r.wd !== bus_if.write_data || r.strb !== bus_if.strobe) begin
                    r.stable = 1'b0;
                end
                vn++;
                if (bus_if.ready) begin
                    r.vcyc = vn;
                    req_log.push_back(r);
                    vn = 0;
                end
            end else begin
                vn = 0;
            end
            if (rsp_valid && rsp_ready) rsp_log.push_back('{rsp_status, rsp_rdata, rsp_timeout, cyc});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input rggen_access a, input logic [AW-1:0] ad, input logic [BW-1:0] wd,
                                input logic [BW/8-1:0] sb, input int w, input rggen_status st,
                                input logic [BW-1:0] rd, input bit lat);
        txn_t t;
        t.acc = a;
        t.addr = ad;
        t.wd = wd;
        t.strb = sb;
        t.w = w;
        t.st = st;
        t.rd = rd;
        t.acc_c = 0;
        t.lat = lat;
        return t;
    endfunction

    function automatic logic exp_timeout(input int w);
        return (TO != 0) && (w + 1 >= TO);
    endfunction

    task automatic issue(input txn_t t);
        bit ok;
        ok = 1'b0;
        cfg_q.push_back(t);
        cmd_valid = 1'b1;
        cmd_access = t.acc;
        cmd_address = t.addr;
        cmd_wdata = t.wd;
        cmd_strobe = t.strb;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
        end
        if (!ok) check("cmd_accept", cmd_ready, 1);
        t.acc_c = cyc;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int n);
        for (int i = 0; i < 400 && rsp_log.size() < n; i++) @(negedge clk);
        check("rsp_count", rsp_log.size(), n);
    endtask

    task automatic compare_all();
        txn_t e;
        req_t r;
        rsp_t p;
        while (exp_q.size() > 0 && rsp_log.size() > 0 && req_log.size() > 0) begin
            e = exp_q.pop_front();
            r = req_log.pop_front();
            p = rsp_log.pop_front();
            check("req_access", r.acc, e.acc);
            check("req_address", r.addr, e.addr);
            check("req_write_data", r.wd, e.wd);
            check("req_strobe", r.strb, e.strb);
            check("req_valid_cycles", r.vcyc, e.w + 1);
            check("req_stable", r.stable, 1);
            check("rsp_status", p.st, e.st);
            check("rsp_read_data", p.rd, e.rd);
            check("rsp_timeout", p.to, exp_timeout(e.w));
            if (e.lat) check("rsp_latency", p.c - e.acc_c, e.w + 2);
        end
        exp_q.delete();
        req_log.delete();
        rsp_log.delete();
    endtask

    task automatic drain();
        wait_rsps(exp_q.size());
        compare_all();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        rggen_access acc_tab[3];
        txn_t        t1;
        txn_t        t2;
        int          first_c;
        bit          seen;
        acc_tab = '{RGGEN_READ, RGGEN_POSTED_WRITE, RGGEN_WRITE};
        cmd_valid = 1'b0;
        cmd_access = RGGEN_READ;
        cmd_address = '0;
        cmd_wdata = '0;
        cmd_strobe = '0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_bus_valid", bus_if.valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_status", rsp_status, RGGEN_OKAY);
        check("rst_rsp_read_data", rsp_rdata, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(mk(RGGEN_WRITE, 8'h10, 32'hDEADBEEF, 4'hF, 0, RGGEN_OKAY, 32'h0BAD_F00D, 1'b1));
        drain();
        issue(mk(RGGEN_READ, 8'h20, 32'h0, 4'h0, 3, RGGEN_OKAY, 32'h12345678, 1'b1));
        drain();
        issue(mk(RGGEN_WRITE, 8'h24, 32'hA5A5_5A5A, 4'h3, 6, RGGEN_SLAVE_ERROR, 32'h0, 1'b1));
        drain();
        issue(mk(RGGEN_READ, 8'h28, 32'h0, 4'h0, 2, RGGEN_OKAY, 32'hCAFE_0002, 1'b1));
        drain();

        // response backpressure with a command waiting behind it
        rsp_ready = 1'b0;
        t1 = mk(RGGEN_WRITE, 8'h40, $urandom, 4'hF, 1, RGGEN_EXOKAY, $urandom, 1'b0);
        t2 = mk(RGGEN_READ, 8'h44, 32'h0, 4'h0, 0, RGGEN_OKAY, $urandom, 1'b0);
        issue(t1);
        seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check("bp_rsp_valid", rsp_valid, 1);
        @(posedge clk);
        #1;
        cfg_q.push_back(t2);
        cmd_valid = 1'b1;
        cmd_access = t2.acc;
        cmd_address = t2.addr;
        cmd_wdata = t2.wd;
        cmd_strobe = t2.strb;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid_held", rsp_valid, 1);
            check("bp_rsp_status", rsp_status, t1.st);
            check("bp_rsp_read_data", rsp_rdata, t1.rd);
            check("bp_rsp_timeout", rsp_timeout, exp_timeout(t1.w));
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_bus_valid", bus_if.valid, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_cmd_ready", cmd_ready, 1);
        t2.acc_c = cyc;
        exp_q.push_back(t2);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_next_bus_valid", bus_if.valid, 1);
        @(posedge clk);
        #1;
        drain();

        // back-to-back with a zero-wait slave
        for (int i = 0; i < 8; i++)
            issue(mk(RGGEN_WRITE, AW'(i * 4), $urandom, 4'($urandom), 0, RGGEN_OKAY, $urandom, 1'b1));
        wait_rsps(8);
        if (rsp_log.size() >= 8) begin
            first_c = rsp_log[0].c;
            for (int i = 1; i < 8; i++) check("b2b_spacing", rsp_log[i].c - rsp_log[i-1].c, 2);
            check("b2b_span", rsp_log[7].c - first_c, 14);
        end
        compare_all();
        @(posedge clk);
        #1;

        // reset in the middle of a bus access
        issue(mk(RGGEN_READ, 8'h80, 32'h0, 4'h0, 20, RGGEN_OKAY, 32'h1111_2222, 1'b0));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_bus_valid", bus_if.valid, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_rsp", rsp_log.size(), 0);
        check("abort_no_req", req_log.size(), 0);
        check("abort_cmd_ready_after", cmd_ready, 1);
        @(posedge clk);
        #1;
        issue(mk(RGGEN_READ, 8'h84, 32'h0, 4'h0, 1, RGGEN_OKAY, 32'h3333_4444, 1'b1));
        drain();

        // random single transactions
        for (int i = 0; i < 20; i++) begin
            issue(mk(acc_tab[$urandom_range(2)], AW'($urandom), $urandom, 4'($urandom),
                     int'($urandom_range(7)), rggen_status'($urandom_range(3)), $urandom, 1'b1));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
